// File: rtl/nibble_serial_tx_if.sv
// Word-side handshake and serial line of the nibble transmitter.
// master = the word source / line observer, slave = the transmitter itself.
interface nibble_serial_tx_if;
   logic [3:0] in;
   logic       in_valid;
   logic       in_ready;
   logic       tx_out;
   logic       busy;

   modport master (
      output in,
      output in_valid,
      input  in_ready,
      input  tx_out,
      input  busy
   );

   modport slave (
      input  in,
      input  in_valid,
      output in_ready,
      output tx_out,
      output busy
   );
endinterface

// File: rtl/nibble_serial_tx.sv
// Framed, odd-parity, LSB-first bit-serial transmitter for 4-bit words.
// Frame: start(0), d0..d3, parity, stop(1); every bit lasts CLKS_PER_BIT cycles.
module nibble_serial_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   nibble_serial_tx_if.slave bus,
   output logic [2:0]        state_dbg
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [3:0]    shift, shift_n;
   logic          par, par_n;
   logic          tx, tx_n;
   logic          bit_done;

   // Handshake: a word is taken on any rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, so in_valid during a frame is simply held off.
   assign bit_done = (cnt == CNT_MAX);

   always_comb begin
      state_n = state;
      cnt_n   = bit_done ? '0 : cnt + CW'(1);
      idx_n   = idx;
      shift_n = shift;
      par_n   = par;
      tx_n    = tx;
      case (state)
         IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
            if (bus.in_valid) begin
               state_n = START;
               shift_n = bus.in;
               par_n   = ~(^bus.in);
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_n = DATA;
               idx_n   = 2'd0;
               tx_n    = shift[0];
            end
         end
         DATA: begin
            // tx is loaded one edge ahead, so the next data bit is shift[1].
            if (bit_done) begin
               if (idx == 2'd3) begin
                  state_n = PARITY;
                  tx_n    = par;
               end else begin
                  shift_n = {1'b0, shift[3:1]};
                  tx_n    = shift[1];
                  idx_n   = idx + 2'd1;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_n = IDLE;
               idx_n   = 2'd0;
               tx_n    = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= 2'd0;
         shift <= 4'd0;
         par   <= 1'b0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
         par   <= par_n;
         tx    <= tx_n;
      end
   end

   assign bus.tx_out   = tx;
   assign bus.in_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign state_dbg    = state;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: one instance at N=4, one at N=1,
// frames checked bit-by-bit against hand-computed line sequences.
module tb_nibble_serial_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   nibble_serial_tx_if ifa ();
   nibble_serial_tx_if ifb ();
   logic [2:0] state_a, state_b;

   nibble_serial_tx #(.CLKS_PER_BIT(4)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifa.slave),
      .state_dbg (state_a)
   );

   nibble_serial_tx #(.CLKS_PER_BIT(1)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifb.slave),
      .state_dbg (state_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      int         n;
      logic [3:0] data;
      logic [0:6] frame;
      bit         change_in;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic get_tx(input int sel);
      return (sel != 0) ? ifb.tx_out : ifa.tx_out;
   endfunction

   function automatic logic get_rdy(input int sel);
      return (sel != 0) ? ifb.in_ready : ifa.in_ready;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel != 0) ? ifb.busy : ifa.busy;
   endfunction

   task automatic drive(input int sel, input logic [3:0] d, input logic v);
      if (sel != 0) begin
         ifb.in       = d;
         ifb.in_valid = v;
      end else begin
         ifa.in       = d;
         ifa.in_valid = v;
      end
   endtask

   // Entered at the falling edge of cycle 1; returns at the falling edge of cycle 7N.
   task automatic check_frame(input int sel, input int n, input logic [0:6] exp);
      for (int c = 1; c <= 7 * n; c++) begin
         if (c > 1) @(negedge clk);
         chk("frame_bit", {7'd0, get_tx(sel)}, {7'd0, exp[(c - 1) / n]});
         chk("ready_low", {7'd0, get_rdy(sel)}, 8'd0);
         chk("busy_high", {7'd0, get_busy(sel)}, 8'd1);
      end
   endtask

   task automatic send_frame(input int sel, input int n, input logic [3:0] d,
                             input logic [0:6] exp, input bit change_in);
      @(negedge clk);
      drive(sel, d, 1'b1);
      chk("ready_before_accept", {7'd0, get_rdy(sel)}, 8'd1);
      @(posedge clk);
      @(negedge clk);
      drive(sel, change_in ? 4'h0 : d, 1'b0);
      check_frame(sel, n, exp);
      @(negedge clk);
      chk("idle_tx", {7'd0, get_tx(sel)}, 8'd1);
      chk("ready_back", {7'd0, get_rdy(sel)}, 8'd1);
   endtask

   initial begin
      vecs[0] = '{sel: 0, n: 4, data: 4'b1010, frame: 7'b0010111, change_in: 1'b0};
      vecs[1] = '{sel: 0, n: 4, data: 4'b0111, frame: 7'b0111001, change_in: 1'b1};
      vecs[2] = '{sel: 0, n: 4, data: 4'b1001, frame: 7'b0100111, change_in: 1'b0};
      vecs[3] = '{sel: 0, n: 4, data: 4'b0000, frame: 7'b0000011, change_in: 1'b1};
      vecs[4] = '{sel: 1, n: 1, data: 4'b1000, frame: 7'b0000101, change_in: 1'b0};

      drive(0, 4'h0, 1'b0);
      drive(1, 4'h0, 1'b0);

      // Reset with no accept
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_tx", {7'd0, get_tx(s)}, 8'd1);
         chk("rst_ready", {7'd0, get_rdy(s)}, 8'd1);
         chk("rst_busy", {7'd0, get_busy(s)}, 8'd0);
      end
      chk("rst_state", {5'd0, state_a}, 8'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_after_rst_a", {7'd0, get_tx(0)}, 8'd1);
         chk("idle_after_rst_b", {7'd0, get_tx(1)}, 8'd1);
      end

      // Table-driven single frames
      for (int i = 0; i < 5; i++)
         send_frame(vecs[i].sel, vecs[i].n, vecs[i].data, vecs[i].frame, vecs[i].change_in);

      // Back-to-back with in_valid held high: F then 0, one idle-high cycle between
      @(negedge clk);
      drive(0, 4'hF, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 4'h0, 1'b1);
      check_frame(0, 4, 7'b0111111);
      @(negedge clk);
      chk("b2b_gap_tx", {7'd0, get_tx(0)}, 8'd1);
      chk("b2b_gap_ready", {7'd0, get_rdy(0)}, 8'd1);
      @(negedge clk);
      check_frame(0, 4, 7'b0000011);
      drive(0, 4'h0, 1'b0);
      @(negedge clk);
      chk("b2b_end_tx", {7'd0, get_tx(0)}, 8'd1);
      chk("b2b_end_ready", {7'd0, get_rdy(0)}, 8'd1);
      @(negedge clk);
      chk("b2b_no_third", {7'd0, get_rdy(0)}, 8'd1);

      // Reset pulse during d1 of a frame for 4'h5
      @(negedge clk);
      drive(0, 4'h5, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 4'h0, 1'b0);
      repeat (9) @(negedge clk);
      chk("mid_d1_bit", {7'd0, get_tx(0)}, 8'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", {7'd0, get_tx(0)}, 8'd1);
      chk("async_rst_ready", {7'd0, get_rdy(0)}, 8'd1);
      chk("async_rst_busy", {7'd0, get_busy(0)}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_resume_tx", {7'd0, get_tx(0)}, 8'd1);
         chk("no_resume_ready", {7'd0, get_rdy(0)}, 8'd1);
      end
      send_frame(0, 4, 4'h3, 7'b0110011, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
